// File: rtl/uart_tx_param.sv
//------------------------------------------------------------------------------
// uart_tx_param -- parameterised UART transmitter.
//
// Sends one frame per accepted request: a start bit (0), DATA_BITS payload
// bits LSB first, an optional parity bit, then one or two stop bits (1).
// Every serial bit lasts exactly CLKS_PER_BIT bclk cycles.
//
// Optional feature: define UART_TX_PARITY_EN to compile in the PARITY state
// and parity generation. Without it, parity_mode is accepted but ignored and
// frames never carry a parity bit.
//
// Parameters
//   DATA_BITS    payload bits per frame (5..9)
//   CLKS_PER_BIT bclk cycles per serial bit (>= 2)
//
// Ports
//   bclk         clock, rising edge
//   rst          synchronous active-high reset
//   tx_valid     frame request
//   tx_ready     block can accept a frame (high only while idle)
//   tx_din       payload, LSB sent first
//   parity_mode  00 none, 01 even, 10 odd, 11 none
//   stop2        1 = two stop bits, 0 = one
//   tx_busy      frame in progress (inverse of tx_ready)
//   tx_done      one-cycle pulse on the edge that ends the frame
//   tx_data      registered serial line, idle high
//------------------------------------------------------------------------------
module uart_tx_param #(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                 bclk,
   input  logic                 rst,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   input  logic [DATA_BITS-1:0] tx_din,
   input  logic [1:0]           parity_mode,
   input  logic                 stop2,
   output logic                 tx_busy,
   output logic                 tx_done,
   output logic                 tx_data
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = $clog2(DATA_BITS);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] ST_PARITY = 3'd3;
`endif
   localparam logic [2:0] ST_STOP   = 3'd4;

   logic [2:0]           state;
   logic [BAUD_W-1:0]    baud_cnt;
   logic [BIT_W-1:0]     bit_cnt;     // data bit index in DATA, stop bit index in STOP
   logic [DATA_BITS-1:0] data_sh;     // latched payload, shifted right as bits go out
   logic                 stop2_q;
   logic                 bit_end;
   logic                 accept;

`ifdef UART_TX_PARITY_EN
   logic                 par_en_q;
   logic                 par_bit_q;
`else
   logic                 unused_parity_mode;
   assign unused_parity_mode = ^parity_mode;
`endif

   assign tx_ready = (state == ST_IDLE);
   assign tx_busy  = ~tx_ready;
   assign bit_end  = (baud_cnt == BAUD_LAST);
   assign accept   = tx_ready & tx_valid;

   // Frame parameters are captured once at acceptance so later input changes
   // cannot disturb the frame in flight.
   // NOTE: these datapath registers carry no reset; each is loaded on
   // acceptance before it is ever read, so a reset would only add fan-out.
   always_ff @(posedge bclk) begin
      if (accept) begin
         data_sh <= tx_din;
         stop2_q <= stop2;
`ifdef UART_TX_PARITY_EN
         // 01 and 10 enable parity; bit 1 of the mode selects odd (inverted).
         par_en_q  <= ^parity_mode;
         par_bit_q <= (^tx_din) ^ parity_mode[1];
`endif
      end else if (state == ST_DATA && bit_end) begin
         data_sh <= data_sh >> 1;
      end
   end

   // NOTE: all state below is updated with non-blocking assignments so every
   // register samples the pre-edge values, independent of statement order.
   always_ff @(posedge bclk) begin
      if (rst) begin
         state    <= ST_IDLE;
         tx_data  <= 1'b1;
         tx_done  <= 1'b0;
         baud_cnt <= '0;
         bit_cnt  <= '0;
      end else begin
         tx_done <= 1'b0;

         // Baud counter idles at zero and reloads at every bit boundary.
         baud_cnt <= (state == ST_IDLE || bit_end) ? '0 : baud_cnt + BAUD_ONE;

         case (state)
            ST_IDLE: begin
               if (tx_valid) begin
                  // Start bit drives the line on the acceptance edge itself.
                  state   <= ST_START;
                  tx_data <= 1'b0;
                  bit_cnt <= '0;
               end
            end

            ST_START: begin
               if (bit_end) begin
                  state   <= ST_DATA;
                  tx_data <= data_sh[0];
               end
            end

            ST_DATA: begin
               if (bit_end) begin
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                     if (par_en_q) begin
                        state   <= ST_PARITY;
                        tx_data <= par_bit_q;
                     end else begin
                        state   <= ST_STOP;
                        tx_data <= 1'b1;
                     end
`else
                     state   <= ST_STOP;
                     tx_data <= 1'b1;
`endif
                  end else begin
                     // data_sh shifts on this same edge, so bit 1 is the next bit.
                     bit_cnt <= bit_cnt + BIT_ONE;
                     tx_data <= data_sh[1];
                  end
               end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (bit_end) begin
                  state   <= ST_STOP;
                  tx_data <= 1'b1;
               end
            end
`endif

            ST_STOP: begin
               if (bit_end) begin
                  if (stop2_q && bit_cnt == '0) begin
                     bit_cnt <= BIT_ONE;
                  end else begin
                     state   <= ST_IDLE;
                     tx_done <= 1'b1;
                     bit_cnt <= '0;
                  end
               end
            end

            default: begin
               state   <= ST_IDLE;
               tx_data <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_param.sv
//------------------------------------------------------------------------------
// tb_uart_tx_param -- self-checking bench for uart_tx_param.
//
// Two instances share clock, reset and frame inputs: dut_a (DATA_BITS=8) and
// dut_b (DATA_BITS=5), both with CLKS_PER_BIT=4. A reference model expands
// each requested frame into the expected per-cycle line state
// {tx_data, tx_busy, tx_ready, tx_done}, which is compared every cycle on the
// falling edge. Parity expectations follow UART_TX_PARITY_EN.
//------------------------------------------------------------------------------
module tb_uart_tx_param;

   localparam int CPB  = 4;
   localparam int NB_A = 8;
   localparam int NB_B = 5;

`ifdef UART_TX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   // Idle line: data 1, busy 0, ready 1, done 0.
   localparam logic [3:0] IDLE_OBS = 4'b1010;

   logic       bclk    = 1'b0;
   logic       rst     = 1'b1;
   logic       a_valid = 1'b0;
   logic       b_valid = 1'b0;
   logic [7:0] din     = 8'h00;
   logic [1:0] mode    = 2'b00;
   logic       stop2   = 1'b0;

   logic a_ready, a_busy, a_done, a_data;
   logic b_ready, b_busy, b_done, b_data;

   uart_tx_param #(.DATA_BITS(NB_A), .CLKS_PER_BIT(CPB)) dut_a (
      .bclk        (bclk),
      .rst         (rst),
      .tx_valid    (a_valid),
      .tx_ready    (a_ready),
      .tx_din      (din),
      .parity_mode (mode),
      .stop2       (stop2),
      .tx_busy     (a_busy),
      .tx_done     (a_done),
      .tx_data     (a_data)
   );

   uart_tx_param #(.DATA_BITS(NB_B), .CLKS_PER_BIT(CPB)) dut_b (
      .bclk        (bclk),
      .rst         (rst),
      .tx_valid    (b_valid),
      .tx_ready    (b_ready),
      .tx_din      (din[NB_B-1:0]),
      .parity_mode (mode),
      .stop2       (stop2),
      .tx_busy     (b_busy),
      .tx_done     (b_done),
      .tx_data     (b_data)
   );

   always #5 bclk = ~bclk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [3:0] exp_q[$];

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (data,busy,ready,done)", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] obs(input bit sel);
      return sel ? {b_data, b_busy, b_ready, b_done} : {a_data, a_busy, a_ready, a_done};
   endfunction

   task automatic set_valid(input bit sel, input logic v);
      if (sel) b_valid = v;
      else     a_valid = v;
   endtask

   task automatic scramble();
      din   = 8'($urandom);
      mode  = 2'($urandom);
      stop2 = 1'($urandom);
   endtask

   task automatic tick();
      @(posedge bclk);
      @(negedge bclk);
   endtask

   // Reference model: list the serial bits of the frame, hold each for CPB
   // cycles, then one idle cycle carrying the done pulse.
   task automatic push_frame(input bit sel, input logic [7:0] d,
                             input logic [1:0] m, input bit s2);
      int   nb;
      bit   pe;
      bit   pb;
      logic line[$];
      nb = sel ? NB_B : NB_A;
      pe = PAR_EN && (m == 2'b01 || m == 2'b10);
      pb = (m == 2'b10);
      line.push_back(1'b0);
      for (int i = 0; i < nb; i++) begin
         line.push_back(d[i]);
         pb = pb ^ d[i];
      end
      if (pe) line.push_back(pb);
      line.push_back(1'b1);
      if (s2) line.push_back(1'b1);
      foreach (line[i])
         for (int c = 0; c < CPB; c++)
            exp_q.push_back({line[i], 1'b1, 1'b0, 1'b0});
      exp_q.push_back(4'b1011);
   endtask

   task automatic wait_ready(input bit sel, input string name);
      int n;
      logic [3:0] o;
      n = 0;
      o = obs(sel);
      while (o[1] !== 1'b1 && n < 200) begin
         tick();
         o = obs(sel);
         n++;
      end
      check({name, " ready"}, o, IDLE_OBS);
   endtask

   // Sends one frame, or two back-to-back with tx_valid held, and compares
   // every cycle against the model. Called on a falling edge.
   task automatic run(input string name, input bit sel, input int nfr,
                      input logic [7:0] d0, input logic [1:0] m0, input bit s0,
                      input logic [7:0] d1, input logic [1:0] m1, input bit s1);
      int l1;
      int sz;
      exp_q.delete();
      push_frame(sel, d0, m0, s0);
      l1 = exp_q.size();
      if (nfr == 2) push_frame(sel, d1, m1, s1);
      sz = exp_q.size();
      wait_ready(sel, name);
      set_valid(sel, 1'b1);
      din   = d0;
      mode  = m0;
      stop2 = s0;
      tick();
      for (int k = 0; k < sz; k++) begin
         check($sformatf("%s c%0d", name, k), obs(sel), exp_q[k]);
         if (nfr == 2) begin
            if (k == 0) begin
               din   = d1;
               mode  = m1;
               stop2 = s1;
            end else if (k >= l1) begin
               set_valid(sel, 1'b0);
               scramble();
            end
         end else begin
            // Wiggle request and frame inputs while busy; they must be ignored.
            scramble();
            set_valid(sel, (k < sz - 1) ? 1'($urandom) : 1'b0);
         end
         tick();
      end
      set_valid(sel, 1'b0);
      check({name, " after"}, obs(sel), IDLE_OBS);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rd0, rd1;
      logic [1:0] rm0, rm1;
      bit         rs0, rs1, rsel;
      int         rn;

      // Reset state, including reset winning over a simultaneous request.
      @(negedge bclk);
      a_valid = 1'b1;
      b_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("reset a%0d", i), obs(1'b0), IDLE_OBS);
         check($sformatf("reset b%0d", i), obs(1'b1), IDLE_OBS);
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
      rst     = 1'b0;
      tick();
      check("post_reset a", obs(1'b0), IDLE_OBS);

      // Directed frames.
      run("a5",       1'b0, 1, 8'hA5, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);
      run("par_even", 1'b0, 1, 8'h07, 2'b01, 1'b0, 8'h00, 2'b00, 1'b0);
      run("par_odd",  1'b0, 1, 8'h07, 2'b10, 1'b0, 8'h00, 2'b00, 1'b0);
      run("par_11",   1'b0, 1, 8'h07, 2'b11, 1'b0, 8'h00, 2'b00, 1'b0);
      run("stop2",    1'b0, 1, 8'hFF, 2'b00, 1'b1, 8'h00, 2'b00, 1'b0);
      run("b2b",      1'b0, 2, 8'h00, 2'b00, 1'b0, 8'h55, 2'b00, 1'b0);
      run("db5",      1'b1, 1, 8'h13, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);

      // Reset asserted on cycle 13 of a 0x00 frame.
      exp_q.delete();
      push_frame(1'b0, 8'h00, 2'b00, 1'b0);
      wait_ready(1'b0, "rst_mid");
      din   = 8'h00;
      mode  = 2'b00;
      stop2 = 1'b0;
      a_valid = 1'b1;
      tick();
      for (int k = 0; k < 13; k++) begin
         check($sformatf("rst_mid c%0d", k), obs(1'b0), exp_q[k]);
         a_valid = 1'b0;
         if (k == 12) rst = 1'b1;
         tick();
      end
      check("rst_mid edge", obs(1'b0), IDLE_OBS);
      rst = 1'b0;
      for (int k = 0; k < 45; k++) begin
         tick();
         check($sformatf("rst_mid idle c%0d", k), obs(1'b0), IDLE_OBS);
      end
      run("rst_after", 1'b0, 1, 8'h00, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);

      // Randomised frames on both widths, some back-to-back.
      for (int i = 0; i < 24; i++) begin
         rsel = 1'($urandom);
         rd0  = 8'($urandom);
         rd1  = 8'($urandom);
         rm0  = 2'($urandom);
         rm1  = 2'($urandom);
         rs0  = 1'($urandom);
         rs1  = 1'($urandom);
         rn   = ($urandom_range(3) == 0) ? 2 : 1;
         if (rsel) begin
            rd0 = rd0 & 8'h1F;
            rd1 = rd1 & 8'h1F;
         end
         run($sformatf("rnd%0d", i), rsel, rn, rd0, rm0, rs0, rd1, rm1, rs1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame; legal range 5..9.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning bclk cycles per serial bit; legal range >= 2.
REQ-003 The block SHALL have one clock, bclk; reset rst is synchronous and active-high.
REQ-004 Ports SHALL be exactly as follows:
- bclk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- tx_valid  in  1  frame request
- tx_ready  out  1  block can accept a frame
- tx_din  in  DATA_BITS  payload, LSB sent first
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 none
- stop2  in  1  1 = two stop bits, 0 = one
- tx_busy  out  1  frame in progress
- tx_done  out  1  one-cycle end-of-frame pulse
- tx_data  out  1  serial line, idle high

Function
REQ-005 A frame SHALL be accepted on a rising edge where tx_valid=1 and tx_ready=1; tx_din, parity_mode and stop2 SHALL be latched on that edge and ignored thereafter until the next acceptance.
REQ-006 tx_ready SHALL be 1 only in state IDLE; tx_busy SHALL equal the inverse of tx_ready.
REQ-007 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on acceptance
- START -> DATA after 1 bit time
- DATA -> PARITY after DATA_BITS bit times if parity is enabled, else DATA -> STOP
- PARITY -> STOP after 1 bit time
- STOP -> IDLE after 1 bit time (stop2=0) or 2 bit times (stop2=1)
REQ-008 A bit time SHALL be exactly CLKS_PER_BIT bclk cycles, timed by a baud counter of $clog2(CLKS_PER_BIT) bits that reloads at every bit boundary.
REQ-009 tx_data SHALL be registered:
- IDLE: 1
- START: 0
- DATA: latched payload bits, LSB first
- PARITY: parity bit
- STOP: 1
REQ-010 tx_data SHALL go low on the acceptance edge, giving zero cycles of latency from acceptance to start-bit line change.
REQ-011 The parity bit SHALL be the XOR of all latched payload bits for even parity, and its inverse for odd parity.
REQ-012 tx_done SHALL pulse high for exactly one cycle on the edge where STOP -> IDLE; tx_ready rises on that same edge.
REQ-013 With tx_valid held high, back-to-back frames SHALL be separated by exactly one idle-high bclk cycle, giving a frame period of N*CLKS_PER_BIT+1 cycles, where N = 1 + DATA_BITS + parity(0/1) + stop(1/2).
REQ-014 Changes on tx_din, parity_mode or stop2 during a frame SHALL NOT affect that frame.
REQ-015 tx_valid deasserted while tx_ready=0 SHALL have no effect; there is no abort.

Reset
REQ-016 While rst=1, on each bclk edge the block SHALL set:
- state to IDLE
- tx_data to 1
- tx_ready to 1
- tx_busy to 0
- tx_done to 0
- baud and bit counters to 0
REQ-017 rst asserted mid-frame SHALL truncate the frame immediately; tx_data returns high on that edge and no tx_done is generated.
REQ-018 rst SHALL take priority over a simultaneous acceptance.

Configuration
REQ-019 Macro UART_TX_PARITY_EN, when defined, SHALL compile in the PARITY state and parity generation per REQ-011.
REQ-020 When UART_TX_PARITY_EN is undefined:
- the parity_mode port SHALL remain present but be ignored
- DATA SHALL always go directly to STOP
- frames SHALL never contain a parity bit

Verification
REQ-021 Frame, no parity: DATA_BITS=8, CLKS_PER_BIT=4, tx_din=0xA5, parity_mode=00, stop2=0.
- tx_data SHALL be 0,1,0,1,0,0,1,0,1,1, each held 4 cycles
- tx_done SHALL pulse 40 cycles after acceptance
REQ-022 Frame, parity: macro defined, tx_din=0x07.
- parity_mode=01 SHALL give parity bit 1
- parity_mode=10 SHALL give parity bit 0
- both frames SHALL be 11 bits (44 cycles)
REQ-023 Two stop bits: stop2=1, tx_din=0xFF, no parity -> 11-bit frame; the final 8 cycles SHALL be high; tx_done SHALL pulse at cycle 44.
REQ-024 Back-to-back: tx_valid held high, tx_din=0x00 then 0x55 -> the second start bit SHALL begin exactly 41 cycles after the first acceptance, preceded by one high cycle.
REQ-025 Reset mid-frame: rst pulsed at cycle 13 of a 0x00 frame -> on that edge:
- tx_data SHALL be 1
- tx_ready SHALL be 1
- no tx_done SHALL occur
- the next acceptance SHALL produce a complete, correct frame
REQ-026 Override DATA_BITS=5, tx_din=5'b10011, macro undefined -> line SHALL be 0,1,1,0,0,1,1; the frame SHALL be 7 bits.
